// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the debug port, oversampling TCK/TMS/TDI on iclk.
// Optional test reset input trstn is enabled by defining DP_TAP_TRST_EN.
module dp_tap_ctrl #(
  parameter int              IR_W         = 4,
  parameter logic [IR_W-1:0] IDCODE_INSTR = IR_W'(1),
  parameter logic [IR_W-1:0] BYPASS_INSTR = '1
) (
  input  logic            iclk,
  input  logic            ireset,
`ifdef DP_TAP_TRST_EN
  input  logic            trstn,
`endif
  input  logic            tck,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic            sdi,
  input  logic            sdo_br,
  input  logic            sdo_dr,
  output logic            clock_dr,
  output logic            shift_dr,
  output logic            update_dr,
  output logic [IR_W-1:0] ir,
  output logic            sel_bypass
);

  localparam logic [3:0] TEST_LOGIC_RESET = 4'hF;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'hC;
  localparam logic [3:0] SELECT_DR        = 4'h7;
  localparam logic [3:0] CAPTURE_DR       = 4'h6;
  localparam logic [3:0] SHIFT_DR         = 4'h2;
  localparam logic [3:0] EXIT1_DR         = 4'h1;
  localparam logic [3:0] PAUSE_DR         = 4'h3;
  localparam logic [3:0] EXIT2_DR         = 4'h0;
  localparam logic [3:0] UPDATE_DR        = 4'h5;
  localparam logic [3:0] SELECT_IR        = 4'h4;
  localparam logic [3:0] CAPTURE_IR       = 4'hE;
  localparam logic [3:0] SHIFT_IR         = 4'hA;
  localparam logic [3:0] EXIT1_IR         = 4'h9;
  localparam logic [3:0] PAUSE_IR         = 4'hB;
  localparam logic [3:0] EXIT2_IR         = 4'h8;
  localparam logic [3:0] UPDATE_IR        = 4'hD;

  logic [2:0]      tck_sync_q, tck_sync_d;
  logic [1:0]      tms_sync_q, tms_sync_d;
  logic [1:0]      tdi_sync_q, tdi_sync_d;
  logic            tck_rise, tck_fall, tms_s;
  logic [3:0]      state_q, state_d;
  logic [IR_W-1:0] ir_shift_q, ir_shift_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  logic            tap_rst;

  // Test reset clears the TAP state but leaves the synchronizers running.
`ifdef DP_TAP_TRST_EN
  assign tap_rst = ireset | ~trstn;
`else
  assign tap_rst = ireset;
`endif

  assign tck_sync_d = {tck_sync_q[1:0], tck};
  assign tms_sync_d = {tms_sync_q[0], tms};
  assign tdi_sync_d = {tdi_sync_q[0], tdi};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
    end
  end

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms_s    = tms_sync_q[1];
  assign sdi      = tdi_sync_q[1];

  function automatic logic [3:0] next_state(input logic [3:0] s, input logic m);
    case (s)
      TEST_LOGIC_RESET: next_state = m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = m ? SELECT_DR  : RUN_TEST_IDLE;
      SELECT_DR:        next_state = m ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR:       next_state = m ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:         next_state = m ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:         next_state = m ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:         next_state = m ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:         next_state = m ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:        next_state = m ? SELECT_DR  : RUN_TEST_IDLE;
      SELECT_IR:        next_state = m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = m ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:         next_state = m ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:         next_state = m ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:         next_state = m ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:         next_state = m ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:        next_state = m ? SELECT_DR  : RUN_TEST_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    tdo_d      = tdo_q;
    tdo_en_d   = tdo_en_q;

    if (tck_rise) begin
      if (state_q == CAPTURE_IR) ir_shift_d = IR_W'(2'b01);
      if (state_q == SHIFT_IR)   ir_shift_d = {sdi, ir_shift_q[IR_W-1:1]};
      state_d = next_state(state_q, tms_s);
    end

    // TDO changes on the falling TCK so the host samples it stable on the next rise.
    if (tck_fall) begin
      if (state_q == UPDATE_IR) ir_d = ir_shift_q;
      case (state_q)
        SHIFT_DR: begin
          tdo_d    = sel_bypass ? sdo_br : sdo_dr;
          tdo_en_d = 1'b1;
        end
        SHIFT_IR: begin
          tdo_d    = ir_shift_q[0];
          tdo_en_d = 1'b1;
        end
        default: begin
          tdo_d    = 1'b0;
          tdo_en_d = 1'b0;
        end
      endcase
    end

    if (state_q == TEST_LOGIC_RESET) ir_d = IDCODE_INSTR;
  end

  always_ff @(posedge iclk or posedge tap_rst) begin
    if (tap_rst) begin
      state_q    <= TEST_LOGIC_RESET;
      ir_shift_q <= '0;
      ir_q       <= IDCODE_INSTR;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  assign clock_dr   = tck_rise & ((state_q == CAPTURE_DR) | (state_q == SHIFT_DR));
  assign shift_dr   = (state_q == SHIFT_DR);
  assign update_dr  = tck_fall & (state_q == UPDATE_DR);
  assign ir         = ir_q;
  assign sel_bypass = (ir_q == BYPASS_INSTR);
  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Bench for dp_tap_ctrl: vector table, corner sequences and a random run against a TAP model.
// Build with DP_TAP_TRST_EN defined to also exercise the trstn input.
module tb_dp_tap_ctrl;
  localparam logic [3:0] IDCODE = 4'b0001;
  localparam logic [3:0] BYPASS = 4'b1111;

  logic       iclk = 1'b0;
  logic       ireset, tck, tms, tdi, sdo_br, sdo_dr;
  logic       tdo, tdo_en, sdi, clock_dr, shift_dr, update_dr, sel_bypass;
  logic [3:0] ir;
`ifdef DP_TAP_TRST_EN
  logic       trstn;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int clk_cnt  = 0;
  int upd_cnt  = 0;
  logic br_q;

  dp_tap_ctrl dut (
    .iclk(iclk), .ireset(ireset),
`ifdef DP_TAP_TRST_EN
    .trstn(trstn),
`endif
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en), .sdi(sdi),
    .sdo_br(sdo_br), .sdo_dr(sdo_dr), .clock_dr(clock_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .ir(ir), .sel_bypass(sel_bypass)
  );

  always #5 iclk = ~iclk;

  // One-bit bypass register: captures 0, shifts sdi.
  always @(posedge iclk or posedge ireset) begin
    if (ireset)        br_q <= 1'b0;
    else if (clock_dr) br_q <= shift_dr ? sdi : 1'b0;
  end
  assign sdo_br = br_q;

  always @(negedge iclk) begin
    if (clock_dr)  clk_cnt++;
    if (update_dr) upd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full TCK period; returns shift_dr during TCK high and tdo/tdo_en after the fall.
  task automatic tck_cycle(input logic t_ms, input logic t_di,
                           output logic o_shift, output logic o_tdo, output logic o_en);
    @(negedge iclk);
    tms = t_ms; tdi = t_di; clk_cnt = 0; upd_cnt = 0;
    repeat (4) @(negedge iclk);
    tck = 1'b1;
    repeat (6) @(negedge iclk);
    o_shift = shift_dr;
    repeat (2) @(negedge iclk);
    tck = 1'b0;
    repeat (5) @(negedge iclk);
    o_tdo = tdo; o_en = tdo_en;
  endtask

  task automatic tck_seq(input logic [15:0] ms, input int n, output logic o_shift);
    logic t, e;
    for (int i = 0; i < n; i++) tck_cycle(ms[i], 1'b0, o_shift, t, e);
  endtask

  // From TLR or RTI: load a 4-bit instruction and return to RTI.
  task automatic load_ir(input logic [3:0] val);
    logic s, t, e;
    tck_seq(16'b0_0110, 5, s);
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, val[i], s, t, e);
    tck_seq(16'b01, 2, s);
  endtask

  // Behavioural TAP model
  typedef enum int {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  typedef struct {
    logic tms, tdi;
    logic exp_shift, exp_tdo, exp_en;
    logic [3:0] exp_ir;
    int exp_clk, exp_upd;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic s, t, e;
    tap_t m_st;
    logic [3:0] m_ir, m_irsh;
    logic m_br, t_ms, t_di, e_tdo, e_clk;

    vecs[0]  = '{0, 0, 0, 0, 0, 4'h1, 0, 0};  // RTI
    vecs[1]  = '{1, 0, 0, 0, 0, 4'h1, 0, 0};  // Select-DR
    vecs[2]  = '{1, 0, 0, 0, 0, 4'h1, 0, 0};  // Select-IR
    vecs[3]  = '{0, 0, 0, 0, 0, 4'h1, 0, 0};  // Capture-IR
    vecs[4]  = '{0, 0, 0, 1, 1, 4'h1, 0, 0};  // Shift-IR, captured 01 LSB first
    vecs[5]  = '{0, 1, 0, 0, 1, 4'h1, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 1, 4'h1, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 1, 4'h1, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 0, 4'h1, 0, 0};  // Exit1-IR
    vecs[9]  = '{1, 0, 0, 0, 0, 4'hF, 0, 0};  // Update-IR
    vecs[10] = '{0, 0, 0, 0, 0, 4'hF, 0, 0};  // RTI
    vecs[11] = '{1, 0, 0, 0, 0, 4'hF, 0, 0};  // Select-DR
    vecs[12] = '{0, 0, 0, 0, 0, 4'hF, 0, 0};  // Capture-DR
    vecs[13] = '{0, 0, 1, 0, 1, 4'hF, 1, 0};  // Shift-DR, bypass captured 0
    vecs[14] = '{0, 1, 1, 1, 1, 4'hF, 1, 0};
    vecs[15] = '{0, 0, 1, 0, 1, 4'hF, 1, 0};
    vecs[16] = '{0, 1, 1, 1, 1, 4'hF, 1, 0};
    vecs[17] = '{1, 1, 0, 0, 0, 4'hF, 1, 0};  // Exit1-DR
    vecs[18] = '{1, 0, 0, 0, 0, 4'hF, 0, 1};  // Update-DR
    vecs[19] = '{0, 0, 0, 0, 0, 4'hF, 0, 0};  // RTI

    tck = 0; tms = 1; tdi = 0; sdo_dr = 0; ireset = 1;
`ifdef DP_TAP_TRST_EN
    trstn = 1;
`endif
    repeat (3) @(negedge iclk);
    check("rst_tdo", tdo, 0);
    check("rst_tdo_en", tdo_en, 0);
    check("rst_sdi", sdi, 0);
    check("rst_clock_dr", clock_dr, 0);
    check("rst_shift_dr", shift_dr, 0);
    check("rst_update_dr", update_dr, 0);
    check("rst_ir", ir, IDCODE);
    check("rst_sel_bypass", sel_bypass, 0);
    ireset = 0;
    repeat (2) @(negedge iclk);

    for (int i = 0; i < 20; i++) begin
      tck_cycle(vecs[i].tms, vecs[i].tdi, s, t, e);
      check($sformatf("vec%0d_shift_dr", i), s, vecs[i].exp_shift);
      check($sformatf("vec%0d_tdo", i), t, vecs[i].exp_tdo);
      check($sformatf("vec%0d_tdo_en", i), e, vecs[i].exp_en);
      check($sformatf("vec%0d_ir", i), ir, vecs[i].exp_ir);
      check($sformatf("vec%0d_clock_dr_cnt", i), clk_cnt, vecs[i].exp_clk);
      check($sformatf("vec%0d_update_dr_cnt", i), upd_cnt, vecs[i].exp_upd);
    end
    check("sel_bypass_after_load", sel_bypass, 1);

    // Five TMS=1 rises from a random state reach Test-Logic-Reset.
    for (int i = 0; i < 7; i++) tck_cycle(1'($urandom % 2), 1'($urandom % 2), s, t, e);
    tck_seq(16'h001F, 5, s);
    check("tlr5_ir", ir, IDCODE);
    check("tlr5_tdo_en", tdo_en, 0);
    check("tlr5_shift_dr", s, 0);
    check("tlr5_sel_bypass", sel_bypass, 0);

    // No TCK edges while in Shift-DR: FSM holds, strobes stay low.
    load_ir(BYPASS);
    tck_seq(16'b0010, 4, s);
    check("idle_in_shift", s, 1);
    clk_cnt = 0; upd_cnt = 0;
    repeat (60) @(negedge iclk);
    check("idle_clock_dr_cnt", clk_cnt, 0);
    check("idle_update_dr_cnt", upd_cnt, 0);
    check("idle_shift_dr", shift_dr, 1);

    // ireset mid-Shift-DR.
    tck_cycle(0, 1, s, t, e);
    check("pre_rst_tdo_en", e, 1);
    check("pre_rst_ir", ir, BYPASS);
    ireset = 1;
    @(negedge iclk);
    check("mid_rst_tdo", tdo, 0);
    check("mid_rst_tdo_en", tdo_en, 0);
    check("mid_rst_ir", ir, IDCODE);
    check("mid_rst_clock_dr", clock_dr, 0);
    check("mid_rst_shift_dr", shift_dr, 0);
    ireset = 0;
    tck_seq(16'b0010, 4, s);
    check("post_rst_path_to_shift_dr", s, 1);

`ifdef DP_TAP_TRST_EN
    // trstn during Shift-IR returns to TLR without TCK edges.
    tck_seq(16'h001F, 5, s);
    load_ir(BYPASS);
    tck_seq(16'b0011, 4, s);
    tck_cycle(0, 0, s, t, e);
    check("pre_trst_tdo_en", e, 1);
    trstn = 0;
    repeat (2) @(negedge iclk);
    check("trst_ir", ir, IDCODE);
    check("trst_tdo", tdo, 0);
    check("trst_tdo_en", tdo_en, 0);
    trstn = 1;
    tck_seq(16'b0010, 4, s);
    check("post_trst_path_to_shift_dr", s, 1);
`endif

    // Random run against the model, starting from a fresh reset.
    ireset = 1;
    repeat (2) @(negedge iclk);
    ireset = 0;
    m_st = TLR; m_ir = IDCODE; m_irsh = 4'h0; m_br = 1'b0;
    for (int i = 0; i < 300; i++) begin
      t_ms   = 1'($urandom % 2);
      t_di   = 1'($urandom % 2);
      sdo_dr = 1'($urandom % 2);
      e_clk  = (m_st == CAP_DR) || (m_st == SH_DR);
      if (m_st == CAP_IR) m_irsh = 4'd1;
      if (m_st == SH_IR)  m_irsh = (m_irsh >> 1) | (4'(t_di) << 3);
      if (m_st == CAP_DR) m_br = 1'b0;
      if (m_st == SH_DR)  m_br = t_di;
      m_st = tap_next(m_st, t_ms);
      if (m_st == UPD_IR) m_ir = m_irsh;
      if (m_st == TLR)    m_ir = IDCODE;
      if (m_st == SH_DR)      e_tdo = (m_ir == BYPASS) ? m_br : sdo_dr;
      else if (m_st == SH_IR) e_tdo = m_irsh[0];
      else                    e_tdo = 1'b0;
      tck_cycle(t_ms, t_di, s, t, e);
      check($sformatf("rnd%0d_shift_dr", i), s, m_st == SH_DR);
      check($sformatf("rnd%0d_tdo", i), t, e_tdo);
      check($sformatf("rnd%0d_tdo_en", i), e, (m_st == SH_DR) || (m_st == SH_IR));
      check($sformatf("rnd%0d_ir", i), ir, m_ir);
      check($sformatf("rnd%0d_sel_bypass", i), sel_bypass, m_ir == BYPASS);
      check($sformatf("rnd%0d_clock_dr_cnt", i), clk_cnt, e_clk);
      check($sformatf("rnd%0d_update_dr_cnt", i), upd_cnt, m_st == UPD_DR);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
